sipo_rx: RTL

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_pkg.sv | 14 +
 rtl/sipo_rx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sipo_pkg.sv
// Shared types for the serial-in parallel-out receiver.
// The PARITY state exists only when SIPO_RX_PARITY_EN is defined.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01
`ifdef SIPO_RX_PARITY_EN
        ,
        PARITY = 2'b10
`endif
    } state_t;

endpackage

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver with a held output register and overrun flag.
// Define SIPO_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun
`ifdef SIPO_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nx;
    logic [WIDTH-1:0] frame;
    logic             take;
    logic             start;
    logic             done;
    logic             load;
    logic             drop;

    assign take  = bit_valid && !frame_start;
    assign start = bit_valid && frame_start;

    assign sreg_nx = (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], bit_in}
                                      : {bit_in, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                if (start) begin
                    state_nx = SHIFT;
                end else if (take && cnt == LAST) begin
`ifdef SIPO_RX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef SIPO_RX_PARITY_EN
            PARITY: begin
                if (start)     state_nx = SHIFT;
                else if (take) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done  = 1'b0;
        frame = sreg_nx;
`ifdef SIPO_RX_PARITY_EN
        frame = sreg;
        if (state == PARITY && take) done = 1'b1;
`else
        if (state == SHIFT && take && cnt == LAST) done = 1'b1;
`endif
    end

    assign load = done && (!out_valid || out_ready);
    assign drop = done && out_valid && !out_ready;

    // A frame_start always restarts the frame, whatever state we are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (start) begin
            cnt  <= CW'(1);
            sreg <= sreg_nx;
        end else if (take) begin
            case (state)
                SHIFT: begin
                    sreg <= sreg_nx;
                    cnt  <= done ? '0 : cnt + 1'b1;
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: cnt <= '0;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_out   <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            par_out   <= frame;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

`ifdef SIPO_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    parity_err <= 1'b0;
        else if (load) parity_err <= ^sreg ^ bit_in;
    end
`endif

endmodule
